uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Responder side of the toggle-handshake MMIO UART channel. It sits behind the I/O port.
//  Each change of mmio_update is one CPU write of mmio_data_in. The byte is queued in a FIFO
//  and serialised on tx as 8N1, LSB first. Status is fed back to the I/O port for CPU polling.
// PARAMETERS
//  CLK_FREQ    27_000_000  system clock in Hz
//  BAUD        115_200     line rate in bit/s
//  FIFO_DEPTH  16          TX queue entries; power of two, >= 2
// PORTS
//  clk            in   1              system clock, rising edge
//  rst_n          in   1              asynchronous active-low reset
//  mmio_data_in   in   8              byte to send; sampled on the write cycle
//  mmio_update    in   1              toggle; every level change is one write
//  ovf_clr        in   1              single-cycle pulse; clears overflow
//  tx             out  1              serial line; idles high
//  tx_busy        out  1              high while a frame is on the line or the FIFO is non-empty
//  fifo_full      out  1              FIFO holds FIFO_DEPTH entries
//  fifo_count     out  $clog2(D)+1    current FIFO occupancy
//  overflow       out  1              sticky; a write arrived while full
// BEHAVIOUR
//  - Reset values: tx=1, tx_busy=0, fifo_full=0, fifo_count=0, overflow=0.
//    FSM=IDLE, FIFO is empty. Reset asserted mid-frame aborts the frame and tx goes high at once.
//  - Write detect: upd_q is a registered copy of mmio_update; write = (mmio_update != upd_q) && armed.
//    The first clock after reset release loads upd_q and sets armed, with no write.
//    This means a toggle level left over from before reset does not produce a spurious byte.
//  - Write handling:
//    - Not full: push mmio_data_in at the detecting edge.
//    - Full: drop the byte and set overflow.
//    - Full with a pop in the same cycle: the push is accepted and overflow stays unchanged.
//  - overflow clears on ovf_clr. If ovf_clr and a new overflow occur in the same cycle, overflow ends up set.
//  - Baud: DIV = (CLK_FREQ + BAUD/2) / BAUD, an integer constant. Each bit lasts exactly DIV clocks.
//    The counter reloads at every bit boundary.
//  - FSM: IDLE -> START -> DATA(x8) -> STOP -> IDLE/START.
//    - IDLE: if the FIFO is non-empty, pop into shift_reg, load the counter, drive tx=0, go to START.
//    - START: after DIV clocks, go to DATA with bit_idx=0.
//    - DATA: tx = shift_reg[bit_idx]. After DIV clocks, increment bit_idx. After bit 7, go to STOP.
//    - STOP: tx=1 for DIV clocks. At the end, if the FIFO is non-empty, pop and go straight to START.
//      Otherwise go to IDLE. Back-to-back frames are exactly 10*DIV clocks apart.
//  - Latency: mmio_update toggles after edge k, with FSM in IDLE and FIFO empty.
//    Push at edge k+1, pop at edge k+2, tx low after edge k+2.
//  - tx is driven from a flop, so the line never glitches. The data byte is latched at pop time;
//    later FIFO traffic never alters a frame in flight.
//  - fifo_count wraps neither way. Underflow cannot occur because pops are gated by not-empty.
// STRUCTURE
//  - Shared package uart_pkg:
//    - tx_state_t enum (IDLE, START, DATA, STOP).
//    - Function baud_div(CLK_FREQ, BAUD).
//    - Constants UART_DATA_BITS=8, UART_STOP_BITS=1.
//  - Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH):
//    - Ports push/pop/din/dout/full/empty/count.
//    - Simultaneous push+pop is allowed when full or empty.
//    - Same clk/rst_n.
//  - Top: toggle detector, overflow flag, baud counter, bit index, shift register, FSM.
// TESTING (CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=16)
//  1. Single byte: toggle with 0xA5 from idle.
//     -> tx low 2 clocks later.
//     -> Line bits 0,1,0,1,0,0,1,0,1 then stop=1; each bit 16 clocks; 160-clock frame.
//     -> tx_busy falls after the stop bit.
//  2. Burst: 4 toggles on consecutive cycles with 0x01,0x02,0x03,0x04.
//     -> Four frames, gap-free, starts 160 clocks apart, bytes in order.
//     -> fifo_count peaks at 3 or 4 and returns to 0.
//  3. Overflow: 18 writes while the first frame transmits.
//     -> fifo_full=1 and overflow=1.
//     -> The extra byte is dropped; 17 bytes are sent (1 in flight + 16 queued).
//     -> ovf_clr pulse -> overflow=0.
//  4. Full plus pop: FIFO full, then a write lands on the pop cycle.
//     -> Byte accepted, overflow stays 0.
//  5. Reset mid-frame: assert rst_n=0 in DATA bit 3.
//     -> tx=1 immediately; count=0; busy=0.
//     -> Release with mmio_update=1: no frame emitted until the next toggle.
//  6. Stale toggle: hold mmio_update constant for 1000 clocks after reset.
//     -> tx stays high and fifo_count stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state type, frame constants and baud divisor helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_STOP_BITS = 1;

    // Rounded clocks-per-bit divisor.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is honoured when full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// MMIO UART transmitter: toggle-handshake write port feeding a TX FIFO and an 8N1 serialiser.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 27_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  mmio_data_in,
    input  logic                        mmio_update,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        fifo_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int unsigned   DIV      = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t     state;
    logic          upd_q;
    logic          armed;
    logic          write;
    logic          pop;
    logic          bit_end;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [7:0]    shift_reg;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;

    // armed keeps a toggle level left over from before reset from counting as a write.
    assign write   = (mmio_update != upd_q) && armed;
    assign bit_end = (baud_cnt == '0);
    assign pop     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
    assign tx_busy = (state != IDLE) || !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (write),
        .pop   (pop),
        .din   (mmio_data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_q    <= 1'b0;
            armed    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            upd_q <= mmio_update;
            armed <= 1'b1;
            if (write && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift_reg <= fifo_dout;
                        baud_cnt  <= DIV_M1;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= DIV_M1;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= DIV_M1;
                        if (bit_idx == LAST_BIT) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                STOP: begin
                    // Popping straight into START keeps back-to-back frames gap-free.
                    if (bit_end) begin
                        if (pop) begin
                            shift_reg <= fifo_dout;
                            baud_cnt  <= DIV_M1;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: queue/frame-time reference model, line decoder and directed plus random traffic.
module tb_uart_tx_mmio;
    localparam int unsigned CLK_FREQ = 1_600_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int          DEPTH    = 16;
    localparam int          BITLEN   = 16;
    localparam int          FRAME    = 10 * BITLEN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mmio_data_in = 8'h00;
    logic       mmio_update = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic [4:0] fifo_count;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    uart_tx_mmio #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mmio_data_in (mmio_data_in),
        .mmio_update  (mmio_update),
        .ovf_clr      (ovf_clr),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a byte queue plus "which clock of the current frame are we on".
    byte unsigned m_q[$];
    byte unsigned sent_q[$];
    byte unsigned m_byte;
    bit           m_active;
    bit           m_ovf;
    bit           m_armed;
    bit           m_prev;
    int           m_clk;
    bit           m_wr;
    bit           m_pop;
    bit           m_full;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            sent_q.delete();
            m_active = 0;
            m_ovf    = 0;
            m_armed  = 0;
            m_prev   = 0;
            m_clk    = 0;
        end else begin
            m_wr    = m_armed && (mmio_update != m_prev);
            m_prev  = mmio_update;
            m_armed = 1;
            m_pop   = (m_q.size() > 0) && (!m_active || m_clk == FRAME - 1);
            m_full  = (m_q.size() == DEPTH);
            if (m_pop) begin
                m_byte = m_q.pop_front();
                sent_q.push_back(m_byte);
            end
            if (m_wr && (!m_full || m_pop)) m_q.push_back(mmio_data_in);
            if (m_wr && m_full && !m_pop) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            if (m_pop) begin
                m_active = 1;
                m_clk    = 0;
            end else if (m_active) begin
                m_clk++;
                if (m_clk == FRAME) begin
                    m_active = 0;
                    m_clk    = 0;
                end
            end
        end
    end

    function automatic int exp_tx();
        int b;
        if (!m_active) return 1;
        b = m_clk / BITLEN;
        if (b == 0) return 0;
        if (b <= 8) return int'(m_byte[b-1]);
        return 1;
    endfunction

    always @(negedge clk) begin
        check("tx", int'(tx), exp_tx());
        check("tx_busy", int'(tx_busy), int'(m_active || m_q.size() != 0));
        check("fifo_count", int'(fifo_count), m_q.size());
        check("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
        check("overflow", int'(overflow), int'(m_ovf));
    end

    // Line decoder: samples mid-bit and compares each frame against what the model popped.
    bit         rx_on;
    int         rx_cnt;
    logic [7:0] rx_sh;
    byte unsigned rx_log[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on  = 0;
            rx_cnt = 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on  = 1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt >= 24 && rx_cnt < 144 && rx_cnt % BITLEN == 8) rx_sh[rx_cnt/BITLEN - 1] = tx;
            if (rx_cnt == 152) begin
                check("rx_stop_bit", int'(tx), 1);
                check("rx_byte", int'(rx_sh), (sent_q.size() != 0) ? int'(sent_q.pop_front()) : -1);
                rx_log.push_back(rx_sh);
                rx_on = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic write(input logic [7:0] d);
        mmio_data_in = d;
        mmio_update  = ~mmio_update;
        step();
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || m_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_within_budget", int'(n < budget), 1);
        repeat (4) step();
    endtask

    task automatic wait_frame_clk(input int target, input int budget);
        int n = 0;
        while (!(m_active && m_clk == target) && n < budget) begin
            step();
            n++;
        end
        check("frame_position_reached", int'(n < budget), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] a5_line;
        int         peak;
        int         nsent;

        repeat (3) step();
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(tx_busy), 0);
        check("reset_count", int'(fifo_count), 0);
        check("reset_overflow", int'(overflow), 0);
        rst_n = 1'b1;
        repeat (3) step();

        // Single byte 0xA5: start, LSB-first data, stop.
        a5_line = 10'b11_0100_1010;
        write(8'hA5);
        check("a5_tx_before_pop", int'(tx), 1);
        check("a5_count_after_push", int'(fifo_count), 1);
        step();
        check("a5_tx_low_two_clocks", int'(tx), 0);
        repeat (8) step();
        check("a5_line_bit0", int'(tx), int'(a5_line[0]));
        for (int j = 1; j < 10; j++) begin
            repeat (BITLEN) step();
            check($sformatf("a5_line_bit%0d", j), int'(tx), int'(a5_line[j]));
        end
        repeat (7) step();
        check("a5_busy_last_stop_clock", int'(tx_busy), 1);
        step();
        check("a5_busy_after_stop", int'(tx_busy), 0);
        wait_idle(400);

        // Burst of four consecutive writes.
        rx_log.delete();
        peak = 0;
        for (int i = 1; i <= 4; i++) begin
            write(8'(i));
            if (int'(fifo_count) > peak) peak = fifo_count;
        end
        for (int n = 0; n < 800 && (m_active || m_q.size() != 0); n++) begin
            if (int'(fifo_count) > peak) peak = fifo_count;
            step();
        end
        wait_idle(400);
        check("burst_peak_3_or_4", int'(peak == 3 || peak == 4), 1);
        check("burst_frames", rx_log.size(), 4);
        for (int i = 0; i < 4 && i < rx_log.size(); i++) check($sformatf("burst_byte%0d", i), int'(rx_log[i]), i + 1);

        // Overflow: 18 writes during the first frame.
        rx_log.delete();
        for (int i = 0; i < 18; i++) write(8'($urandom));
        check("ovf_full", int'(fifo_full), 1);
        check("ovf_count", int'(fifo_count), 16);
        check("ovf_flag", int'(overflow), 1);
        pulse_clr();
        check("ovf_cleared", int'(overflow), 0);
        wait_idle(17 * FRAME + 400);
        check("ovf_frames_sent", rx_log.size(), 17);

        // Full FIFO, write landing on the pop cycle.
        rx_log.delete();
        for (int i = 0; i < 17; i++) write(8'($urandom));
        check("fullpop_full_before", int'(fifo_full), 1);
        wait_frame_clk(FRAME - 1, 400);
        write(8'($urandom));
        check("fullpop_no_overflow", int'(overflow), 0);
        check("fullpop_count", int'(fifo_count), 16);
        wait_idle(18 * FRAME + 400);
        check("fullpop_frames_sent", rx_log.size(), 18);

        // Reset mid-frame in data bit 3, release with mmio_update high.
        write(8'h3C);
        wait_frame_clk(4 * BITLEN + 6, 400);
        rst_n = 1'b0;
        mmio_update = 1'b1;
        #1;
        check("midreset_tx_high", int'(tx), 1);
        check("midreset_count", int'(fifo_count), 0);
        check("midreset_busy", int'(tx_busy), 0);
        repeat (3) step();
        rx_log.delete();
        rst_n = 1'b1;
        repeat (1000) step();
        check("stale_tx_high", int'(tx), 1);
        check("stale_count", int'(fifo_count), 0);
        check("stale_no_frames", rx_log.size(), 0);
        write(8'h96);
        wait_idle(400);
        check("post_reset_frame", rx_log.size(), 1);

        // Randomised traffic with occasional overflow clears.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 250)) step();
            nsent = $urandom_range(1, 6);
            for (int k = 0; k < nsent; k++) write(8'($urandom));
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end
        wait_idle(20 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
